// File: rtl/stage_f_pkg.sv
// Shared fetch-stage types and helpers: state encoding, constants, and the
// redirect target / mode-toggle rules that the hazard unit also uses.
package stage_f_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  // Writeback redirect outranks execute; targets are always word aligned.
  function automatic logic [31:0] redirect_target(
    input logic        pcsrc_w,
    input logic [31:0] result_w,
    input logic [31:0] pctarget_e
  );
    logic [31:0] tgt;
    tgt = pctarget_e;
    if (pcsrc_w) begin
      tgt = result_w;
    end else begin
      tgt = pctarget_e;
    end
    return {tgt[31:2], 2'b00};
  endfunction

  function automatic logic mode_toggle(
    input logic pcsrc_e,
    input logic mode_switch_e,
    input logic pcsrc_w
  );
    return pcsrc_e & mode_switch_e & ~pcsrc_w;
  endfunction

endpackage

// File: rtl/stage_f_holdbuf.sv
// 32-bit word register with load enable; holds a stalled instruction word or
// the address of a request that must be drained after a redirect.
module fetch_holdbuf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] word_q;

  // Word storage, captured only when load_i is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= 32'h0000_0000;
    end else if (load_i) begin
      word_q <= d_i;
    end else begin
      word_q <= word_q;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/stage_f.sv
// Fetch stage: owns PC and fetch mode, drives the req/ack instruction port,
// absorbs memory latency, holds a word under stall and drains squashed fetches.
module stage_f
  import stage_f_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic        RESET_ARM = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        ModeSwitchE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        armF,
  output logic        FetchStallF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         arm_q, arm_d;

  logic         redir_s;
  logic [31:0]  redir_tgt_s;
  logic         buf_load_s;
  logic         drop_load_s;
  logic [31:0]  buf_word_s;
  logic [31:0]  drop_addr_s;
  logic         imem_req_s;
  logic [31:0]  imem_addr_s;
  logic [31:0]  instr_s;
  logic         instr_valid_s;
  logic         fetch_stall_s;

  assign redir_s     = PCSrcW | PCSrcE;
  assign redir_tgt_s = redirect_target(PCSrcW, ResultW, PCTargetE);

  fetch_holdbuf u_hold_buf (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (buf_load_s),
    .d_i    (ImemRData),
    .q_o    (buf_word_s)
  );

  fetch_holdbuf u_drop_addr (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (drop_load_s),
    .d_i    (pc_q),
    .q_o    (drop_addr_s)
  );

  // State, PC and mode registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      arm_q   <= RESET_ARM;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      arm_q   <= arm_d;
    end
  end

  // Next-state, PC update and port outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    arm_d         = arm_q;
    imem_req_s    = 1'b0;
    imem_addr_s   = pc_q;
    instr_s       = NOP_INSTR;
    instr_valid_s = 1'b0;
    fetch_stall_s = 1'b0;
    buf_load_s    = 1'b0;
    drop_load_s   = 1'b0;

    if (redir_s) begin
      pc_d = redir_tgt_s;
      if (mode_toggle(PCSrcE, ModeSwitchE, PCSrcW)) begin
        arm_d = ~arm_q;
      end else begin
        arm_d = arm_q;
      end
    end else begin
      pc_d = pc_q;
    end

    case (state_q)
      ST_IDLE: begin
        fetch_stall_s = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (ImemAck && !redir_s) begin
          instr_s       = ImemRData;
          instr_valid_s = 1'b1;
          if (StallF) begin
            buf_load_s = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            pc_d = pc_q + INSTR_BYTES;
          end
        end else if (!ImemAck) begin
          fetch_stall_s = 1'b1;
          if (redir_s) begin
            // The request is still outstanding at the old PC; drain it.
            drop_load_s = 1'b1;
            state_d     = ST_DROP;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redir_s) begin
          state_d = ST_FETCH;
        end else begin
          instr_s       = buf_word_s;
          instr_valid_s = 1'b1;
          if (!StallF) begin
            pc_d    = pc_q + INSTR_BYTES;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_DROP: begin
        imem_req_s    = 1'b1;
        imem_addr_s   = drop_addr_s;
        fetch_stall_s = 1'b1;
        if (ImemAck) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ImemReq     = imem_req_s;
  assign ImemAddr    = imem_addr_s;
  assign InstrF      = instr_s;
  assign InstrValidF = instr_valid_s;
  // IDLE requests a stall, but not while reset itself is asserted.
  assign FetchStallF = fetch_stall_s & rst;
  assign PCF         = pc_q;
  assign PCPlus4F    = pc_q + INSTR_BYTES;
  assign armF        = arm_q;

endmodule

// File: tb/tb_stage_f.sv
// Scoreboard bench for stage_f: a latency-configurable memory model pushes
// expected words on ack; decode-side consumption pops and compares them.
module tb_stage_f;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, PCSrcE, ModeSwitchE, PCSrcW;
  logic [31:0] PCTargetE, ResultW;
  logic        ImemReq, ImemAck;
  logic [31:0] ImemAddr, ImemRData;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        InstrValidF, armF, FetchStallF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  int          stall_cnt;
  logic [31:0] m_pc;
  logic        m_arm;
  logic        req_prev, ack_prev;
  logic [31:0] addr_prev;
  logic        s_req, s_fstall, s_valid, s_arm;
  logic [31:0] s_addr, s_pc, s_pcp4, s_instr;

  stage_f #(.RESET_PC(32'h0000_0100), .RESET_ARM(1'b0)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ModeSwitchE(ModeSwitchE), .PCSrcW(PCSrcW), .ResultW(ResultW),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemRData(ImemRData),
    .InstrF(InstrF), .InstrValidF(InstrValidF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .armF(armF), .FetchStallF(FetchStallF)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0280) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  // One cycle: memory responds, outputs are checked, then the clock advances.
  task automatic step();
    logic        redir;
    logic        exp_valid;
    logic [31:0] tgt;
    if (req_prev && !ack_prev && ImemReq) check_eq("addr_stable", ImemAddr, addr_prev);
    ImemAck   = ImemReq && (wait_cnt >= lat - 1);
    ImemRData = ImemAck ? mem_word(ImemAddr) : $urandom;
    #1;
    s_req = ImemReq; s_addr = ImemAddr; s_fstall = FetchStallF; s_valid = InstrValidF;
    s_pc = PCF; s_pcp4 = PCPlus4F; s_instr = InstrF; s_arm = armF;
    redir = PCSrcE | PCSrcW;
    tgt   = PCSrcW ? ResultW : PCTargetE;
    tgt   = {tgt[31:2], 2'b00};
    check_eq("pc", PCF, m_pc);
    check_eq("pcplus4", PCPlus4F, m_pc + 32'd4);
    check_eq("arm", {31'd0, armF}, {31'd0, m_arm});
    if (ImemAck && !redir && ImemAddr == m_pc && sb.size() == 0)
      sb.push_back('{pc: m_pc, data: ImemRData});
    exp_valid = (sb.size() > 0) && !redir;
    check_eq("valid", {31'd0, InstrValidF}, {31'd0, exp_valid});
    if (exp_valid) check_eq("instr", InstrF, sb[0].data);
    else           check_eq("instr_zero", InstrF, 32'h0);
    if (redir) begin
      sb.delete();
      m_pc = tgt;
      if (PCSrcE && ModeSwitchE && !PCSrcW) m_arm = ~m_arm;
    end else if (exp_valid && !StallF) begin
      void'(sb.pop_front());
      m_pc = m_pc + 32'd4;
    end
    req_prev = ImemReq; ack_prev = ImemAck; addr_prev = ImemAddr;
    @(posedge clk); #1;
    if (req_prev && !ack_prev) wait_cnt++;
    else                       wait_cnt = 0;
  endtask

  task automatic redirect_e(input logic [31:0] tgt, input logic ms);
    PCSrcE = 1'b1; PCTargetE = tgt; ModeSwitchE = ms;
    step();
    PCSrcE = 1'b0; ModeSwitchE = 1'b0;
  endtask

  task automatic reset_model();
    m_pc = 32'h0000_0100; m_arm = 1'b0; sb.delete();
    wait_cnt = 0; req_prev = 1'b0; ack_prev = 1'b0; addr_prev = 32'h0;
  endtask

  initial begin
    rst = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; ModeSwitchE = 1'b0; PCSrcW = 1'b0;
    PCTargetE = 32'h0; ResultW = 32'h0; ImemAck = 1'b0; ImemRData = 32'h0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", {31'd0, ImemReq}, 32'd0);
    check_eq("rst_valid", {31'd0, InstrValidF}, 32'd0);
    check_eq("rst_instr", InstrF, 32'h0);
    check_eq("rst_fstall", {31'd0, FetchStallF}, 32'd0);
    check_eq("rst_pc", PCF, 32'h0000_0100);
    check_eq("rst_arm", {31'd0, armF}, 32'd0);
    rst = 1'b1;

    // Zero-wait streaming after one IDLE cycle.
    step();
    check_eq("idle_stall", {31'd0, s_fstall}, 32'd1);
    check_eq("idle_req", {31'd0, s_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stream_pc", s_pc, 32'h0000_0100 + 32'(i * 4));
      check_eq("stream_addr", s_addr, s_pc);
      check_eq("stream_valid", {31'd0, s_valid}, 32'd1);
    end

    // Three-cycle ack latency at 0x200.
    redirect_e(32'h0000_0200, 1'b0);
    lat = 3; stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("lat_addr", s_addr, 32'h0000_0200);
      if (s_fstall) stall_cnt++;
    end
    check_eq("lat_stalls", 32'(stall_cnt), 32'd2);
    lat = 1;
    step();
    check_eq("lat_next_pc", s_pc, 32'h0000_0204);

    // Decode stall across the ack of 0xDEADBEEF.
    redirect_e(32'h0000_0280, 1'b0);
    StallF = 1'b1;
    step();
    check_eq("hold_ack_instr", s_instr, 32'hDEAD_BEEF);
    step();
    check_eq("hold_req", {31'd0, s_req}, 32'd0);
    check_eq("hold_instr", s_instr, 32'hDEAD_BEEF);
    StallF = 1'b0;
    step();
    check_eq("hold_release_pc", s_pc, 32'h0000_0280);
    step();
    check_eq("hold_next_pc", s_pc, 32'h0000_0284);

    // Redirect to 0x403 while the fetch at 0x300 is still pending.
    redirect_e(32'h0000_0300, 1'b0);
    lat = 4;
    step();
    redirect_e(32'h0000_0403, 1'b0);
    step();
    check_eq("drop_addr", s_addr, 32'h0000_0300);
    check_eq("drop_stall", {31'd0, s_fstall}, 32'd1);
    step();
    check_eq("drop_ack_addr", s_addr, 32'h0000_0300);
    check_eq("drop_ack_valid", {31'd0, s_valid}, 32'd0);
    lat = 1;
    step();
    check_eq("drop_next_addr", s_addr, 32'h0000_0400);

    // Writeback beats execute; then execute alone toggles the mode.
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0500; ModeSwitchE = 1'b1;
    PCSrcW = 1'b1; ResultW = 32'h0000_0600;
    step();
    PCSrcE = 1'b0; PCSrcW = 1'b0; ModeSwitchE = 1'b0;
    step();
    check_eq("prio_pc", s_pc, 32'h0000_0600);
    check_eq("prio_arm", {31'd0, s_arm}, 32'd0);
    redirect_e(32'h0000_0500, 1'b1);
    step();
    check_eq("toggle_pc", s_pc, 32'h0000_0500);
    check_eq("toggle_arm", {31'd0, s_arm}, 32'd1);

    // PC wrap, then reset in the middle of a pending request.
    redirect_e(32'hFFFF_FFFC, 1'b0);
    step();
    check_eq("wrap_pcp4", s_pcp4, 32'h0);
    step();
    check_eq("wrap_pc", s_pc, 32'h0);
    lat = 3;
    step();
    rst = 1'b0;
    ImemAck = 1'b0;
    #1;
    check_eq("midrst_req", {31'd0, ImemReq}, 32'd0);
    check_eq("midrst_pc", PCF, 32'h0000_0100);
    check_eq("midrst_arm", {31'd0, armF}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    reset_model();
    lat = 1;
    step();
    check_eq("rerun_idle_stall", {31'd0, s_fstall}, 32'd1);
    step();
    check_eq("rerun_pc", s_pc, 32'h0000_0100);
    step();
    check_eq("rerun_pc2", s_pc, 32'h0000_0104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stage_f.md
Name: stage_f

Overview:
Fetch stage of the combined ARM/RISC-V pipeline. It owns the PC register and the fetch mode bit, and drives a req/ack instruction-memory port. It produces PCF, PCPlus4F and the fetched word InstrF, which are consumed directly by the decode stage (InstrF feeds its RDD input). It absorbs multi-cycle memory latency, holds a returned word while decode is stalled, and discards in-flight fetches squashed by a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
RESET_ARM, 1'b0, mode bit loaded on reset (1 = ARM, 0 = RISC-V).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low (asserted when 0).
StallF  in  1  hazard-unit stall; holds the PC and holds the fetched word.
PCSrcE  in  1  RISC-V branch/jump taken in execute.
PCTargetE  in  32  target for PCSrcE.
ModeSwitchE  in  1  qualifies PCSrcE; toggles armF on redirect.
PCSrcW  in  1  ARM PC write in writeback.
ResultW  in  32  target for PCSrcW.
ImemReq  out  1  instruction-memory request.
ImemAddr  out  32  request address, word aligned.
ImemAck  in  1  data valid this cycle; may arrive in the same cycle as ImemReq.
ImemRData  in  32  instruction word, valid with ImemAck.
InstrF  out  32  fetched instruction to decode.
InstrValidF  out  1  InstrF holds a live instruction.
PCF  out  32  PC of InstrF.
PCPlus4F  out  32  PCF + 4, wraps mod 2^32.
armF  out  1  current fetch mode.
FetchStallF  out  1  to hazard unit: fetch not ready, stall F/D.

Behaviour:
- Reset (rst=0): PCF=RESET_PC, armF=RESET_ARM, state=IDLE, buffer=0. Outputs during reset: ImemReq=0, InstrValidF=0, InstrF=0, FetchStallF=0.
- Redirect: redir = PCSrcW | PCSrcE. Target is ResultW when PCSrcW=1 (W has priority over E), otherwise PCTargetE. Target bits [1:0] are forced to 0.
- A redirect updates PCF at the next edge in every state, regardless of StallF. armF toggles only when PCSrcE & ModeSwitchE & ~PCSrcW.
- States:
  - IDLE: lasts 1 cycle after reset release, then goes to FETCH. Outputs: ImemReq=0, FetchStallF=1.
  - FETCH: ImemReq=1, ImemAddr=PCF.
    - ack & ~redir & ~StallF: InstrF=ImemRData, InstrValidF=1, PCF<=PCF+4, stay in FETCH.
    - ack & ~redir & StallF: InstrF=ImemRData, InstrValidF=1, buffer<=ImemRData, go to HOLD.
    - ~ack: FetchStallF=1, InstrValidF=0; if redir, go to DROP.
    - ack & redir: data discarded, InstrValidF=0, stay in FETCH.
  - HOLD: ImemReq=0, InstrF=buffer, InstrValidF=1.
    - ~StallF: PCF<=PCF+4, go to FETCH.
    - redir: InstrValidF=0, go to FETCH.
  - DROP: ImemReq=1, ImemAddr=dropaddr (the address latched when the redirect hit), FetchStallF=1, InstrValidF=0.
    - On ack: data discarded, go to FETCH.
    - A further redirect updates PCF and stays in DROP.
- The request address stays stable while ImemReq=1 and ~ImemAck (protocol rule).
- InstrF=0 whenever InstrValidF=0.
- PCPlus4F is combinational from PCF.
- Latency: zero-wait memory gives one instruction per cycle. An N-cycle ack inserts N-1 FetchStallF cycles.
- PC wrap: 32'hFFFF_FFFC+4 = 0, with no flag raised.
- If rst asserts mid-request, the fetch is abandoned immediately. Memory must tolerate a dropped request.

Decomposition:
- Shared package: fetch state enum (IDLE, FETCH, HOLD, DROP), INSTR_BYTES=4, NOP_INSTR=32'h0.
- The redirect-target mux and the mode-toggle rule also go in the package as functions, so the hazard unit can reuse them.
- One natural sub-module: fetch_holdbuf, a 32-bit word register with load enable and async active-low reset, used for both the hold buffer and dropaddr.

Test Plan:
- Reset release, RESET_PC=0x100, zero-wait ack every cycle -> after 1 IDLE cycle, PCF sequence 0x100, 0x104, 0x108 with InstrValidF=1 each cycle; ImemAddr equals PCF.
- ack delayed 3 cycles at PCF=0x200 -> FetchStallF=1 for 2 cycles, ImemAddr held at 0x200, then InstrF=ImemRData, next PCF=0x204.
- StallF=1 for 2 cycles on ack of 0xDEADBEEF -> state HOLD, ImemReq=0, InstrF=0xDEADBEEF stable; PCF advances 1 cycle after StallF falls.
- PCSrcE=1, PCTargetE=0x403 while a fetch at 0x300 is pending -> DROP, ImemAddr stays 0x300 until ack, that data discarded, next fetch at 0x400.
- PCSrcE=1 (0x500, ModeSwitchE=1) and PCSrcW=1 (ResultW=0x600) in the same cycle -> PCF=0x600, armF unchanged; repeat with PCSrcE alone -> PCF=0x500, armF toggles.
- PCF=0xFFFF_FFFC with zero-wait ack -> PCPlus4F=0, next PCF=0; assert rst during a pending ack -> PCF=RESET_PC and ImemReq=0 immediately.
